// File: rtl/sevenseg_scan_if.sv
// ---------------------------------------------------------------------------
// sevenseg_scan_if
//   Bundles the data/strobe inputs and the display outputs of the
//   seven-segment scanner so they can be passed as one port.
//
//   Signals
//     value [15:0]  nibble k (value[4k+3:4k]) is shown on digit k, k=0 rightmost
//     load          one-cycle strobe, captures value into the shadow register
//     an    [3:0]   digit enables, active-low (one low bit, or all high = blank)
//     seg   [6:0]   {g,f,e,d,c,b,a}, active-low
//     busy          high in the cycle whose closing edge advances the scan
//
//   Modports
//     master : the data source / observer (drives value, load)
//     slave  : the scanner itself (drives an, seg, busy)
// ---------------------------------------------------------------------------
interface sevenseg_if;
  logic [15:0] value;
  logic        load;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        busy;

  modport master (
    output value,
    output load,
    input  an,
    input  seg,
    input  busy
  );

  modport slave (
    input  value,
    input  load,
    output an,
    output seg,
    output busy
  );
endinterface

// File: rtl/sevenseg_scan.sv
// ---------------------------------------------------------------------------
// sevenseg_scan
//   Time-multiplexed 4-digit common-anode seven-segment driver. A 16-bit
//   value is captured into a shadow register on a load strobe; the scanner
//   lights one digit per refresh slot of REFRESH_DIV clocks, hex-decoding the
//   matching shadow nibble. an/seg are registered and only change on a slot
//   boundary, so a load in mid-slot never disturbs the digit being shown.
//
//   Parameters
//     REFRESH_DIV  clk cycles per digit slot (>= 2)
//     DIV_W        slot counter width, 2**DIV_W >= REFRESH_DIV
//
//   Ports
//     clk    system clock
//     reset  synchronous, active-high; returns the scanner to its blank
//            start state (first lit digit is digit 0, REFRESH_DIV cycles
//            after release)
//     bus    sevenseg_if.slave : value/load in, an/seg/busy out
//
//   Build option
//     LEADING_ZERO_BLANK_EN : when defined, digits 3..1 are blanked during
//     their slot if that nibble and every nibble above it are zero. Digit 0
//     is always shown. Slot timing is the same either way.
// ---------------------------------------------------------------------------
module sevenseg_scan #(
  parameter int REFRESH_DIV = 100000,
  parameter int DIV_W       = 17
) (
  input  logic       clk,
  input  logic       reset,
  sevenseg_if.slave  bus
);

  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic [1:0]       digit_idx_q, digit_idx_d;
  logic [15:0]      shadow_q, shadow_d;
  logic [3:0]       an_q, an_d;
  logic [6:0]       seg_q, seg_d;
  logic             tick;

  function automatic logic [6:0] hex_decode(input logic [3:0] nib);
    logic [6:0] s;
    case (nib)
      4'h0: s = 7'b1000000;
      4'h1: s = 7'b1111001;
      4'h2: s = 7'b0100100;
      4'h3: s = 7'b0110000;
      4'h4: s = 7'b0011001;
      4'h5: s = 7'b0010010;
      4'h6: s = 7'b0000010;
      4'h7: s = 7'b1111000;
      4'h8: s = 7'b0000000;
      4'h9: s = 7'b0010000;
      4'hA: s = 7'b0001000;
      4'hB: s = 7'b0000011;
      4'hC: s = 7'b1000110;
      4'hD: s = 7'b0100001;
      4'hE: s = 7'b0000110;
      default: s = 7'b0001110;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] k);
    logic [3:0] n;
    case (k)
      2'd0:    n = v[3:0];
      2'd1:    n = v[7:4];
      2'd2:    n = v[11:8];
      default: n = v[15:12];
    endcase
    return n;
  endfunction

  // True when digit k is a leading zero: it and all digits above it are 0.
  function automatic logic leading_zero(input logic [15:0] v, input logic [1:0] k);
    logic z;
    case (k)
      2'd1:    z = (v[15:4]  == 12'h000);
      2'd2:    z = (v[15:8]  == 8'h00);
      2'd3:    z = (v[15:12] == 4'h0);
      default: z = 1'b0;
    endcase
    return z;
  endfunction

  assign tick = (div_cnt_q == DIV_W'(REFRESH_DIV - 1));

  always_comb begin
    div_cnt_d   = tick ? '0 : div_cnt_q + DIV_W'(1);
    digit_idx_d = digit_idx_q;
    an_d        = an_q;
    seg_d       = seg_q;
    // A load coinciding with a tick still lands here, but the decode below
    // reads shadow_q, so that tick shows the old data.
    shadow_d    = bus.load ? bus.value : shadow_q;

    if (tick) begin
      // Index wraps 3 -> 0 naturally in 2 bits; outputs follow the new index.
      digit_idx_d = digit_idx_q + 2'd1;
      an_d        = ~(4'b0001 << digit_idx_d);
      seg_d       = hex_decode(nibble_sel(shadow_q, digit_idx_d));
`ifdef LEADING_ZERO_BLANK_EN
      if (leading_zero(shadow_q, digit_idx_d)) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
`else
      if (leading_zero(shadow_q, digit_idx_d) && 1'b0) begin
        an_d  = 4'b1111;
        seg_d = 7'b1111111;
      end
`endif
    end
  end

  // Reset starts at index 3 so the first tick lands on digit 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt_q   <= '0;
      digit_idx_q <= 2'd3;
      shadow_q    <= 16'h0000;
      an_q        <= 4'b1111;
      seg_q       <= 7'b1111111;
    end else begin
      div_cnt_q   <= div_cnt_d;
      digit_idx_q <= digit_idx_d;
      shadow_q    <= shadow_d;
      an_q        <= an_d;
      seg_q       <= seg_d;
    end
  end

  assign bus.an   = an_q;
  assign bus.seg  = seg_q;
  assign bus.busy = tick;

endmodule

// File: tb/tb_sevenseg_scan.sv
module tb_sevenseg_scan;
  localparam int R = 4;

  logic clk;
  logic reset;

  sevenseg_if bus ();

  sevenseg_scan #(
    .REFRESH_DIV (R),
    .DIV_W       (3)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;

  logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                           7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // Reference model: cycles counted since reset release; every R-th edge
  // shows digit ((cyc/R)-1) mod 4 from the shadow value held before that edge.
  int          m_cyc  = 0;
  logic [15:0] m_sh   = 16'h0;
  logic [3:0]  m_an   = 4'hF;
  logic [6:0]  m_seg  = 7'h7F;
  logic        m_busy = 1'b0;
  logic        m_init = 1'b0;
  logic [15:0] m_seen = 16'h0;

  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, got, exp);
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      if (reset) begin
        m_cyc  = 0;
        m_sh   = 16'h0;
        m_an   = 4'hF;
        m_seg  = 7'h7F;
        m_init = 1'b1;
      end else begin
        m_cyc++;
        if (m_cyc % R == 0) begin
          int k;
          int nib;
          logic blank;
          k     = ((m_cyc / R) - 1) % 4;
          nib   = int'((m_sh >> (4 * k)) & 16'hF);
          blank = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
          blank = (k != 0) && ((m_sh >> (4 * k)) == 16'h0);
`endif
          if (blank) begin
            m_an  = 4'hF;
            m_seg = 7'h7F;
          end else begin
            m_an  = ~(4'(1) << k);
            m_seg = dec[nib];
            m_seen[nib] = 1'b1;
          end
        end
        if (bus.load) m_sh = bus.value;
      end
      m_busy = (m_cyc % R == R - 1);
    end
  end

  // Every cycle once the model is anchored by a reset.
  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("model_an",   16'(bus.an),   16'(m_an));
        chk("model_seg",  16'(bus.seg),  16'(m_seg));
        chk("model_busy", 16'(bus.busy), 16'(m_busy));
      end
    end
  end

  task automatic wait_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    bus.load = 1'b0;
    reset    = 1'b1;
    wait_n(3);
    reset    = 1'b0;
  endtask

  task automatic startup_check(input string tag);
    for (int i = 0; i < 3; i++) begin
      wait_n(1);
      chk({tag, "_blank_an"},  16'(bus.an),  16'hF);
      chk({tag, "_blank_seg"}, 16'(bus.seg), 16'h7F);
    end
    wait_n(1);
    chk({tag, "_first_an"},  16'(bus.an),  16'hE);
    chk({tag, "_first_seg"}, 16'(bus.seg), 16'h40);
  endtask

  logic [3:0] exp_an  [5] = '{4'hE, 4'hD, 4'hB, 4'h7, 4'hE};
  logic [6:0] exp_seg [5] = '{7'h19, 7'h30, 7'h24, 7'h79, 7'h19};

  initial begin
    reset     = 1'b1;
    bus.load  = 1'b0;
    bus.value = 16'h0;
    wait_n(3);
    reset = 1'b0;

    // Startup from reset: three blank cycles, then digit 0 showing 0.
    startup_check("startup");

    // 1234 scanned across all four digits with wrap back to digit 0.
    do_reset();
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    wait_n(1);
    bus.load  = 1'b0;
    wait_n(3);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) wait_n(4);
      chk("scan1234_an",  16'(bus.an),  16'(exp_an[i]));
      chk("scan1234_seg", 16'(bus.seg), 16'(exp_seg[i]));
    end

    // Reset in mid-slot while digit 2 is lit.
    wait_n(8);
    wait_n(2);
    chk("midslot_an_before", 16'(bus.an), 16'hB);
    reset = 1'b1;
    wait_n(1);
    chk("midrst_an",   16'(bus.an),   16'hF);
    chk("midrst_seg",  16'(bus.seg),  16'h7F);
    chk("midrst_busy", 16'(bus.busy), 16'h0);
    reset = 1'b0;
    startup_check("restart");

    // Load coincident with a tick: that slot shows old data, next shows new.
    do_reset();
    bus.value = 16'h1234;
    bus.load  = 1'b1;
    wait_n(1);
    bus.load  = 1'b0;
    wait_n(6);
    bus.value = 16'hABCD;
    bus.load  = 1'b1;
    wait_n(1);
    bus.load  = 1'b0;
    chk("coinc_old_an",  16'(bus.an),  16'hD);
    chk("coinc_old_seg", 16'(bus.seg), 16'h30);
    wait_n(4);
    chk("coinc_new_an",  16'(bus.an),  16'hB);
    chk("coinc_new_seg", 16'(bus.seg), 16'h03);

    // Leading zeros: 0005.
    do_reset();
    bus.value = 16'h0005;
    bus.load  = 1'b1;
    wait_n(1);
    bus.load  = 1'b0;
    wait_n(3);
    chk("lz_d0_an",  16'(bus.an),  16'hE);
    chk("lz_d0_seg", 16'(bus.seg), 16'h12);
    wait_n(4);
`ifdef LEADING_ZERO_BLANK_EN
    chk("lz_d1_an",  16'(bus.an),  16'hF);
    chk("lz_d1_seg", 16'(bus.seg), 16'h7F);
`else
    chk("lz_d1_an",  16'(bus.an),  16'hD);
    chk("lz_d1_seg", 16'(bus.seg), 16'h40);
`endif

    // Continuous capture of 8F00, then random traffic with occasional resets.
    do_reset();
    bus.value = 16'h8F00;
    bus.load  = 1'b1;
    wait_n(40);
    for (int i = 0; i < 3000; i++) begin
      bus.value = 16'($urandom);
      bus.load  = 1'($urandom_range(0, 1));
      reset     = ($urandom_range(0, 199) == 0);
      wait_n(1);
    end
    reset    = 1'b0;
    bus.load = 1'b0;
    wait_n(2);
    chk("hex_coverage", m_seen, 16'hFFFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

endmodule
